// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point FFT stage sequencer.
package fft_pkg;
    localparam int N_POINTS = 8;
    localparam int N_STAGES = 3;

    typedef enum logic [1:0] {LOAD, FEED, DRAIN, OUT} seq_state_t;

    typedef logic [1:0] stage_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction
endpackage

// File: rtl/fft_frame_buffer.sv
// In-place frame store: one write port, one combinational read port.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int DW = 50
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [2:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [2:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [N_POINTS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft8_stage_sequencer.sv
// Frame controller: load 8 samples, run three butterfly passes in place,
// then stream the results out.
module fft8_stage_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 50,
    parameter int BITREV_OUT = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic [DATA_WIDTH-1:0] bf_data_o,
    output logic                  bf_valid_o,
    input  logic                  bf_ready_i,
    output logic [1:0]            bf_stage_o,
    input  logic [DATA_WIDTH-1:0] bf_data_i,
    input  logic                  bf_valid_i,
    output logic                  bf_ready_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam stage_t LAST_PASS = stage_t'(N_STAGES - 1);

    seq_state_t            state_q;
    logic [2:0]            idx_q;
    stage_t                pass_q;
    logic [TW-1:0]         timer_q;
    logic                  s_ready_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  bf_valid_q;
    logic [DATA_WIDTH-1:0] bf_data_q;
    logic                  bf_ready_q;
    stage_t                bf_stage_q;
    logic                  busy_q;
    logic                  err_q;

    logic [2:0]            idx_d;
    logic [2:0]            rd_lin;
    logic [2:0]            rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  s_fire;
    logic                  f_fire;
    logic                  d_fire;
    logic                  m_fire;
    logic                  last;

    assign idx_d  = idx_q + 3'd1;
    assign last   = (idx_q == 3'd7);
    assign s_fire = s_valid_i & s_ready_q;
    assign f_fire = bf_valid_q & bf_ready_i;
    assign d_fire = bf_valid_i & bf_ready_q;
    assign m_fire = m_valid_q & m_ready_i;

    // Read one slot ahead so the registered data is ready on the next beat.
    always_comb begin
        rd_lin = 3'd0;
        if (state_q == FEED || state_q == OUT) begin
            rd_lin = idx_d;
        end
        rd_idx = rd_lin;
        if (state_q == OUT && BITREV_OUT != 0) begin
            rd_idx = bitrev3(rd_lin);
        end
    end

    fft_frame_buffer #(.DW(DATA_WIDTH)) u_buf (
        .clk_i   (clk_i),
        .we_i    (s_fire | d_fire),
        .waddr_i (idx_q),
        .wdata_i (bf_ready_q ? bf_data_i : s_data_i),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LOAD;
            idx_q      <= 3'd0;
            pass_q     <= '0;
            timer_q    <= '0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            bf_valid_q <= 1'b0;
            bf_data_q  <= '0;
            bf_ready_q <= 1'b0;
            bf_stage_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (s_fire) begin
                        idx_q <= idx_d;
                        if (last) begin
                            pass_q     <= '0;
                            s_ready_q  <= 1'b0;
                            bf_valid_q <= 1'b1;
                            bf_data_q  <= rd_data;
                            bf_stage_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (f_fire) begin
                        idx_q <= idx_d;
                        if (last) begin
                            bf_valid_q <= 1'b0;
                            bf_ready_q <= 1'b1;
                            timer_q    <= '0;
                            state_q    <= DRAIN;
                        end else begin
                            bf_data_q <= rd_data;
                        end
                    end
                end
                DRAIN: begin
                    if (d_fire) begin
                        timer_q <= '0;
                        idx_q   <= idx_d;
                        if (last) begin
                            bf_ready_q <= 1'b0;
                            if (pass_q < LAST_PASS) begin
                                pass_q     <= pass_q + 2'd1;
                                bf_stage_q <= pass_q + 2'd1;
                                bf_valid_q <= 1'b1;
                                bf_data_q  <= rd_data;
                                state_q    <= FEED;
                            end else begin
                                m_valid_q <= 1'b1;
                                m_data_q  <= rd_data;
                                m_last_q  <= 1'b0;
                                state_q   <= OUT;
                            end
                        end
                    end else if (timer_q == TMAX) begin
                        // Butterfly stalled: drop the frame and re-arm.
                        err_q      <= 1'b1;
                        idx_q      <= 3'd0;
                        pass_q     <= '0;
                        timer_q    <= '0;
                        bf_ready_q <= 1'b0;
                        bf_stage_q <= '0;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                OUT: begin
                    if (m_fire) begin
                        idx_q <= idx_d;
                        if (last) begin
                            m_valid_q  <= 1'b0;
                            m_last_q   <= 1'b0;
                            pass_q     <= '0;
                            bf_stage_q <= '0;
                            s_ready_q  <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= LOAD;
                        end else begin
                            m_data_q <= rd_data;
                            m_last_q <= (idx_d == 3'd7);
                        end
                    end
                end
            endcase
        end
    end

    assign s_ready_o  = s_ready_q;
    assign m_data_o   = m_data_q;
    assign m_valid_o  = m_valid_q;
    assign m_last_o   = m_last_q;
    assign bf_data_o  = bf_data_q;
    assign bf_valid_o = bf_valid_q;
    assign bf_ready_o = bf_ready_q;
    assign bf_stage_o = bf_stage_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Bench for fft8_stage_sequencer with a stub butterfly and scoreboarded sink.
module tb_fft8_stage_sequencer;
    localparam int W  = 50;
    localparam int H  = 25;
    localparam int TO = 64;

    typedef logic [W-1:0] frame_t [8];

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [W-1:0] s_data_i = '0;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic [W-1:0] m_data_o;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic         m_last_o;
    logic [W-1:0] bf_data_o;
    logic         bf_valid_o;
    logic         bf_ready_i = 1'b0;
    logic [1:0]   bf_stage_o;
    logic [W-1:0] bf_data_i = '0;
    logic         bf_valid_i = 1'b0;
    logic         bf_ready_o;
    logic         busy_o;
    logic         err_o;

    fft8_stage_sequencer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .bf_data_o  (bf_data_o),
        .bf_valid_o (bf_valid_o),
        .bf_ready_i (bf_ready_i),
        .bf_stage_o (bf_stage_o),
        .bf_data_i  (bf_data_i),
        .bf_valid_i (bf_valid_i),
        .bf_ready_o (bf_ready_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];
    logic [1:0]   stage_log [$];

    int stub_lat = 5;
    int stub_mode = 0;
    bit rand_bp = 1'b0;
    int t_last, t_first, t_3rd, t_err;
    bit first_seen = 1'b0;
    int out_beats = 0;
    int err_cnt = 0;

    int st, cnt, wcnt, ocnt, span;
    logic [1:0]   stg;
    logic [W-1:0] sbuf [8];
    logic [W-1:0] obuf [8];
    logic [W-1:0] a, b, e;
    bit           bf_hold, m_hold;
    logic [W-1:0] bf_hold_d, m_hold_d;
    frame_t       f;

    function automatic logic [W-1:0] cx(input int r, input int i);
        return {H'(r), H'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Stub butterfly: collects 8 beats, waits, returns a twiddle-free stage.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            st = 0; cnt = 0; wcnt = 0; ocnt = 0;
            bf_hold = 1'b0;
            bf_valid_i = 1'b0;
            bf_ready_i = 1'b0;
            bf_data_i = '0;
        end else begin
            if (bf_hold) begin
                chk("bf_valid_hold", 64'(bf_valid_o), 64'(1));
                chk("bf_data_hold", 64'(bf_data_o), 64'(bf_hold_d));
            end
            bf_ready_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (st == 1) begin
                if (wcnt > 0) wcnt--;
                if (wcnt == 0) begin
                    st = 2;
                    ocnt = 0;
                end
            end
            bf_valid_i = (st == 2);
            bf_data_i = (st == 2) ? obuf[ocnt] : '0;
            bf_hold = bf_valid_o && !bf_ready_i;
            bf_hold_d = bf_data_o;
            if (bf_valid_o && bf_ready_i) begin
                sbuf[cnt] = bf_data_o;
                stg = bf_stage_o;
                stage_log.push_back(bf_stage_o);
                cnt++;
                if (cnt == 8) begin
                    span = 4 >> stg;
                    for (int i = 0; i < 8; i++) obuf[i] = sbuf[i];
                    if (stub_mode != 1) begin
                        for (int i = 0; i < 8; i++) begin
                            if ((i & span) == 0) begin
                                a = sbuf[i];
                                b = sbuf[i+span];
                                obuf[i] = {a[W-1:H] + b[W-1:H],
                                           a[H-1:0] + b[H-1:0]};
                                obuf[i+span] = {a[W-1:H] - b[W-1:H],
                                                a[H-1:0] - b[H-1:0]};
                            end
                        end
                    end
                    st = 1;
                    wcnt = stub_lat + 1;
                    cnt = 0;
                end
            end
            if (bf_valid_i && bf_ready_o) begin
                ocnt++;
                if (stub_mode == 2 && stg == 2'd1 && ocnt == 3) begin
                    t_3rd = cyc;
                    st = 0;
                end else if (ocnt == 8) begin
                    st = 0;
                end
            end
        end
    end

    // Sink: pops the scoreboard on every result handshake.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            m_ready_i = 1'b0;
            m_hold = 1'b0;
            out_beats = 0;
        end else begin
            if (m_hold) begin
                chk("m_valid_hold", 64'(m_valid_o), 64'(1));
                chk("m_data_hold", 64'(m_data_o), 64'(m_hold_d));
            end
            m_ready_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (err_o) err_cnt++;
            if (m_valid_o && !first_seen) begin
                first_seen = 1'b1;
                t_first = cyc;
            end
            m_hold = m_valid_o && !m_ready_i;
            m_hold_d = m_data_o;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(m_valid_o), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 64'(m_data_o), 64'(e));
                    chk("m_last", 64'(m_last_o), 64'(out_beats % 8 == 7));
                end
                out_beats++;
            end
        end
    end

    task automatic send_frame(input frame_t fr);
        int k = 0;
        int g = 0;
        while (k < 8 && g < 2000) begin
            s_valid_i = 1'b1;
            s_data_i = fr[k];
            if (s_ready_o) begin
                if (k == 7) t_last = cyc;
                k++;
            end
            @(negedge clk_i);
            g++;
        end
        s_valid_i = 1'b0;
        chk("send_done", 64'(k), 64'(8));
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk_i);
            g++;
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk_i);
        chk("rst_s_ready", 64'(s_ready_o), 64'(1));
        chk("rst_m_valid", 64'(m_valid_o), 64'(0));
        chk("rst_m_last", 64'(m_last_o), 64'(0));
        chk("rst_bf_valid", 64'(bf_valid_o), 64'(0));
        chk("rst_bf_ready", 64'(bf_ready_o), 64'(0));
        chk("rst_bf_stage", 64'(bf_stage_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_m_data", 64'(m_data_o), 64'(0));
        chk("rst_bf_data", 64'(bf_data_o), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Impulse
        stub_lat = 2;
        for (int i = 0; i < 8; i++) f[i] = (i == 0) ? cx(1024, 0) : '0;
        for (int i = 0; i < 8; i++) exp_q.push_back(cx(1024, 0));
        stage_log.delete();
        err_cnt = 0;
        out_beats = 0;
        send_frame(f);
        chk("busy_run", 64'(busy_o), 64'(1));
        chk("s_ready_run", 64'(s_ready_o), 64'(0));
        wait_drain("impulse_drain");
        chk("stage_count", 64'(stage_log.size()), 64'(24));
        for (int i = 0; i < stage_log.size(); i++)
            chk("bf_stage", 64'(stage_log[i]), 64'(i / 8));
        chk("impulse_err", 64'(err_cnt), 64'(0));
        chk("impulse_beats", 64'(out_beats), 64'(8));

        // Constant, latency-5 butterfly
        stub_lat = 5;
        for (int i = 0; i < 8; i++) f[i] = cx(256, 0);
        exp_q.push_back(cx(2048, 0));
        for (int i = 1; i < 8; i++) exp_q.push_back('0);
        first_seen = 1'b0;
        send_frame(f);
        wait_drain("const_drain");
        chk("latency", 64'(t_first - t_last), 64'(1 + 3 * (8 + 5 + 8)));

        // Backpressure on both sides
        rand_bp = 1'b1;
        out_beats = 0;
        for (int i = 0; i < 8; i++) f[i] = cx(256, 0);
        exp_q.push_back(cx(2048, 0));
        for (int i = 1; i < 8; i++) exp_q.push_back('0);
        send_frame(f);
        for (int i = 0; i < 8; i++) f[i] = (i == 0) ? cx(1024, 0) : '0;
        for (int i = 0; i < 8; i++) exp_q.push_back(cx(1024, 0));
        send_frame(f);
        wait_drain("bp_drain");
        chk("bp_beats", 64'(out_beats), 64'(16));
        rand_bp = 1'b0;
        repeat (3) @(negedge clk_i);

        // Timeout in pass 1
        stub_mode = 2;
        err_cnt = 0;
        out_beats = 0;
        for (int i = 0; i < 8; i++) f[i] = cx(i + 1, 0);
        send_frame(f);
        g = 0;
        while (!err_o && g < 2000) begin
            @(negedge clk_i);
            g++;
        end
        t_err = cyc;
        chk("timeout_seen", 64'(err_o), 64'(1));
        chk("timeout_delay", 64'(t_err - t_3rd), 64'(TO + 1));
        chk("timeout_s_ready", 64'(s_ready_o), 64'(1));
        chk("timeout_busy", 64'(busy_o), 64'(0));
        @(negedge clk_i);
        chk("err_pulse", 64'(err_o), 64'(0));
        repeat (10) @(negedge clk_i);
        chk("err_count", 64'(err_cnt), 64'(1));
        chk("timeout_no_out", 64'(out_beats), 64'(0));
        stub_mode = 0;

        // Reset in the middle of OUT
        stub_lat = 3;
        for (int i = 0; i < 8; i++) f[i] = (i == 0) ? cx(1024, 0) : '0;
        for (int i = 0; i < 8; i++) exp_q.push_back(cx(1024, 0));
        send_frame(f);
        g = 0;
        while (out_beats < 4 && g < 2000) begin
            @(posedge clk_i);
            g++;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_beats", 64'(out_beats), 64'(4));
        chk("mid_m_valid", 64'(m_valid_o), 64'(0));
        chk("mid_m_last", 64'(m_last_o), 64'(0));
        chk("mid_m_data", 64'(m_data_o), 64'(0));
        chk("mid_s_ready", 64'(s_ready_o), 64'(1));
        chk("mid_busy", 64'(busy_o), 64'(0));
        chk("mid_bf_ready", 64'(bf_ready_o), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) f[i] = cx(256, 0);
        exp_q.push_back(cx(2048, 0));
        for (int i = 1; i < 8; i++) exp_q.push_back('0);
        send_frame(f);
        wait_drain("post_rst_drain");

        // Identity butterfly shows the bit-reversed readout order
        stub_mode = 1;
        for (int i = 0; i < 8; i++) f[i] = W'(i + 1);
        exp_q.push_back(W'(1));
        exp_q.push_back(W'(5));
        exp_q.push_back(W'(3));
        exp_q.push_back(W'(7));
        exp_q.push_back(W'(2));
        exp_q.push_back(W'(6));
        exp_q.push_back(W'(4));
        exp_q.push_back(W'(8));
        send_frame(f);
        wait_drain("ident_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
